// File: rtl/pxie_pkg.sv
// pxie_pkg
//   Shared definitions for the PXIE card-to-host read engine: the
//   controller state encoding, the stream header constants and a helper
//   that assembles the 128-bit header word.
package pxie_pkg;

    localparam logic [15:0] HDR_MAGIC = 16'heb9c;
    localparam logic [15:0] HDR_TAG   = 16'h1010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } c2h_state_e;

    function automatic logic [127:0] make_header(input logic [15:0] addr,
                                                 input logic [15:0] len);
        return {64'h0, HDR_MAGIC, len, addr, HDR_TAG};
    endfunction

endpackage

// File: rtl/pxie_c2h_fifo.sv
// pxie_c2h_fifo
//   Synchronous show-ahead FIFO used as the C2H output buffer. The head
//   word is visible on rdata_o whenever vld_o is high; rdata_o reads as
//   zero while empty so the stream data output is clean after reset.
// Ports
//   clk_i    clock
//   rst_n_i  synchronous active-low reset (flushes pointers and count)
//   push_i   write wdata_i this clock
//   wdata_i  write data
//   pop_i    retire the head word this clock (ignored when empty)
//   rdata_o  head word
//   vld_o    FIFO not empty
//   count_o  words currently stored
module pxie_c2h_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     vld_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves the same clock.
    assign do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign vld_o   = (count_q != '0);
    assign rdata_o = vld_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/pxie_c2h_read.sv
// pxie_c2h_read
//   Reads a block of 128-bit words from a fixed-latency RAM and streams
//   it, preceded by one header word, to the PXIE C2H path.
// Ports
//   I_PXIE_CLK      clock
//   I_Rst_n         synchronous active-low reset
//   I_c2h_addr/len  start word address / word count, sampled on I_c2h_en
//   I_c2h_en        one-cycle request pulse
//   O_ram_addr/rden RAM read address / strobe
//   I_ram_data      RAM data, valid RD_LAT clocks after O_ram_rden
//   O_C2H_DATA/_VLD stream word / valid; I_C2H_RDY stream ready
//   O_busy          request active; O_done completion pulse; O_err reject pulse
//
// state    | meaning
// ST_IDLE  | waiting for I_c2h_en
// ST_HEAD  | header word pushed into the output FIFO
// ST_READ  | issuing one RAM read per clock while buffer space allows
// ST_DRAIN | all reads issued; waiting for data to land and stream out
// ST_DONE  | pulse O_done, drop O_busy, return to idle
module pxie_c2h_read
    import pxie_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         I_PXIE_CLK,
    input  logic         I_Rst_n,
    input  logic [15:0]  I_c2h_addr,
    input  logic [15:0]  I_c2h_len,
    input  logic         I_c2h_en,
    output logic [15:0]  O_ram_addr,
    output logic         O_ram_rden,
    input  logic [127:0] I_ram_data,
    output logic [127:0] O_C2H_DATA,
    output logic         O_C2H_DATA_VLD,
    input  logic         I_C2H_RDY,
    output logic         O_busy,
    output logic         O_done,
    output logic         O_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    c2h_state_e         state_q;
    logic [15:0]        addr_q;
    logic [15:0]        len_q;
    logic [15:0]        next_addr_q;
    logic [15:0]        rem_q;
    logic [15:0]        ram_addr_q;
    logic               rden_q;
    logic [RD_LAT-1:0]  pipe_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               fifo_push;
    logic [127:0]       fifo_wdata;
    logic               fifo_pop;
    logic               fifo_vld;
    logic [CW-1:0]      fifo_count;
    logic [7:0]         occ_net;
    logic               room;

    // pipe_q[i] marks a read whose data is i+1 clocks past its strobe;
    // the last stage lines up with valid I_ram_data.
    always_ff @(posedge I_PXIE_CLK) begin
        if (!I_Rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= rden_q;
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign fifo_pop   = fifo_vld && I_C2H_RDY;
    assign fifo_push  = (state_q == ST_HEAD) || pipe_q[RD_LAT-1];
    assign fifo_wdata = (state_q == ST_HEAD) ? make_header(addr_q, len_q) : I_ram_data;

    // Buffer words plus reads in flight, net of the word leaving this clock.
    // Issuing only while this is below the depth keeps every returning word
    // guaranteed a slot, yet sustains one word per clock when RDY stays high.
    always_comb begin
        occ_net = 8'(fifo_count) + {7'd0, rden_q};
        for (int i = 0; i < RD_LAT; i++) occ_net = occ_net + {7'd0, pipe_q[i]};
        occ_net = occ_net - {7'd0, fifo_pop};
        room    = occ_net < 8'(FIFO_DEPTH);
    end

    always_ff @(posedge I_PXIE_CLK) begin
        if (!I_Rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            next_addr_q <= '0;
            rem_q       <= '0;
            ram_addr_q  <= '0;
            rden_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rden_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= I_c2h_en && (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (I_c2h_en) begin
                        addr_q      <= I_c2h_addr;
                        len_q       <= I_c2h_len;
                        next_addr_q <= I_c2h_addr;
                        rem_q       <= I_c2h_len;
                        busy_q      <= 1'b1;
                        state_q     <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    state_q <= (len_q == 16'd0) ? ST_DRAIN : ST_READ;
                end
                ST_READ: begin
                    if (room) begin
                        rden_q      <= 1'b1;
                        ram_addr_q  <= next_addr_q;
                        next_addr_q <= next_addr_q + 16'd1;
                        rem_q       <= rem_q - 16'd1;
                        if (rem_q == 16'd1) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!rden_q && (pipe_q == '0) && !fifo_vld) state_q <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pxie_c2h_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (128)
    ) u_fifo (
        .clk_i   (I_PXIE_CLK),
        .rst_n_i (I_Rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (O_C2H_DATA),
        .vld_o   (fifo_vld),
        .count_o (fifo_count)
    );

    assign O_C2H_DATA_VLD = fifo_vld;
    assign O_ram_addr     = ram_addr_q;
    assign O_ram_rden     = rden_q;
    assign O_busy         = busy_q;
    assign O_done         = done_q;
    assign O_err          = err_q;

endmodule
